// File: rtl/fft_frame_sequencer_pkg.sv
// fft_seq_pkg: shared state encoding and bit positions for the FFT frame sequencer
package fft_seq_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONFIG   = 2'd1,
    STREAM   = 2'd2,
    WAIT_OUT = 2'd3
  } seq_state_t;
  localparam int ERR_UNEXP   = 0;
  localparam int ERR_MISS    = 1;
  localparam int ERR_TMO     = 2;
  localparam int CFG_FWD_BIT = 0;
endpackage

// File: rtl/fft_err_capture.sv
// fft_err_capture: sticky error flags, a new event beats a simultaneous clear
module fft_err_capture (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] set,
  input  logic       clr,
  output logic [2:0] err
);
  // flags hold until cleared; events arriving with the clear survive it
  always_ff @(posedge clk)
    if (rst) err <= '0;
    else err <= set | (clr ? 3'b000 : err);
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: drives the FFT core one frame at a time (config, NFFT samples, wait for output)
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int NFFT    = 1024,
  parameter int LOG2N   = 10,
  parameter int DW      = 32,
  parameter int CFG_W   = 8,
  parameter int TIMEOUT = 8192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont_mode,
  input  logic             fwd_inv,
  output logic             busy,
  input  logic [DW-1:0]    src_tdata,
  input  logic             src_tvalid,
  output logic             src_tready,
  output logic [CFG_W-1:0] fft_cfg_tdata,
  output logic             fft_cfg_tvalid,
  input  logic             fft_cfg_tready,
  output logic [DW-1:0]    fft_din_tdata,
  output logic             fft_din_tvalid,
  input  logic             fft_din_tready,
  output logic             fft_din_tlast,
  input  logic             fft_dout_tvalid,
  input  logic             fft_dout_tready,
  input  logic             fft_dout_tlast,
  input  logic             ev_tlast_unexpected,
  input  logic             ev_tlast_missing,
  output logic [15:0]      frame_cnt,
  output logic [2:0]       err,
  input  logic             err_clr
);
  localparam int WW = $clog2(TIMEOUT + 1);
  seq_state_t       state;
  logic             fwd_lat;
  logic [LOG2N-1:0] sample_cnt;
  logic [WW-1:0]    wdog;
  logic             beat, last, out_done, tmo;
  logic [2:0]       err_set;
  assign beat           = state == STREAM && src_tvalid && fft_din_tready;
  assign last           = state == STREAM && sample_cnt == LOG2N'(NFFT - 1);
  assign out_done       = state == WAIT_OUT && fft_dout_tvalid && fft_dout_tready && fft_dout_tlast;
  assign tmo            = state == WAIT_OUT && !out_done && wdog == WW'(TIMEOUT - 1);
  assign busy           = state != IDLE;
  assign src_tready     = state == STREAM && fft_din_tready;
  assign fft_din_tvalid = state == STREAM && src_tvalid;
  assign fft_din_tdata  = src_tdata;
  assign fft_din_tlast  = last;
  // config word carries only the direction bit
  always_comb begin
    fft_cfg_tdata = '0;
    fft_cfg_tdata[CFG_FWD_BIT] = fwd_lat;
  end
  // error event sources mapped onto their sticky bit positions
  always_comb begin
    err_set = '0;
    err_set[ERR_UNEXP] = ev_tlast_unexpected;
    err_set[ERR_MISS]  = ev_tlast_missing;
    err_set[ERR_TMO]   = tmo;
  end
  // frame sequencing: config handshake, NFFT-beat stream, output wait with watchdog
  always_ff @(posedge clk)
    if (rst) begin
      state          <= IDLE;
      fft_cfg_tvalid <= 1'b0;
      fwd_lat        <= 1'b0;
      sample_cnt     <= '0;
      wdog           <= '0;
      frame_cnt      <= '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            state          <= CONFIG;
            fwd_lat        <= fwd_inv;
            fft_cfg_tvalid <= 1'b1;
          end
        CONFIG:
          if (fft_cfg_tvalid && fft_cfg_tready) begin
            state          <= STREAM;
            fft_cfg_tvalid <= 1'b0;
            sample_cnt     <= '0;
          end
        STREAM:
          if (beat) begin
            sample_cnt <= last ? '0 : sample_cnt + 1'b1;
            state      <= last ? WAIT_OUT : STREAM;
          end
        WAIT_OUT:
          if (out_done) begin
            frame_cnt      <= frame_cnt + 1'b1;
            wdog           <= '0;
            state          <= cont_mode ? CONFIG : IDLE;
            fft_cfg_tvalid <= cont_mode;
            fwd_lat        <= cont_mode ? fwd_inv : fwd_lat;
          end else if (tmo) begin
            wdog  <= '0;
            state <= IDLE;
          end else
            wdog <= wdog + 1'b1;
      endcase
  fft_err_capture u_err (
    .clk (clk),
    .rst (rst),
    .set (err_set),
    .clr (err_clr),
    .err (err)
  );
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: frame-level checks of the sequencer against a beat/frame model
module tb_fft_frame_sequencer;
  localparam int NFFT = 16, LOG2N = 4, DW = 32, CFG_W = 8, TIMEOUT = 64;
  logic clk = 1'b0;
  logic rst, start, cont_mode, fwd_inv, busy;
  logic [DW-1:0] src_tdata, fft_din_tdata;
  logic src_tvalid, src_tready;
  logic [CFG_W-1:0] fft_cfg_tdata;
  logic fft_cfg_tvalid, fft_cfg_tready;
  logic fft_din_tvalid, fft_din_tready, fft_din_tlast;
  logic fft_dout_tvalid, fft_dout_tready, fft_dout_tlast;
  logic ev_tlast_unexpected, ev_tlast_missing, err_clr;
  logic [15:0] frame_cnt;
  logic [2:0] err;
  int checks = 0, errors = 0;
  logic [15:0] exp_frames;
  logic [2:0] exp_err;
  logic [DW-1:0] frame_data [NFFT];
  typedef struct {
    logic unexp;
    logic miss;
    logic clr;
    logic [2:0] exp;
  } err_vec_t;
  err_vec_t tbl [8];
  int w;

  fft_frame_sequencer #(.NFFT(NFFT), .LOG2N(LOG2N), .DW(DW), .CFG_W(CFG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .cont_mode(cont_mode), .fwd_inv(fwd_inv), .busy(busy),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tready(src_tready),
    .fft_cfg_tdata(fft_cfg_tdata), .fft_cfg_tvalid(fft_cfg_tvalid), .fft_cfg_tready(fft_cfg_tready),
    .fft_din_tdata(fft_din_tdata), .fft_din_tvalid(fft_din_tvalid), .fft_din_tready(fft_din_tready),
    .fft_din_tlast(fft_din_tlast), .fft_dout_tvalid(fft_dout_tvalid), .fft_dout_tready(fft_dout_tready),
    .fft_dout_tlast(fft_dout_tlast), .ev_tlast_unexpected(ev_tlast_unexpected),
    .ev_tlast_missing(ev_tlast_missing), .frame_cnt(frame_cnt), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic fwd);
    fwd_inv = fwd;
    start = 1'b1;
    step;
    start = 1'b0;
    fwd_inv = ~fwd;
  endtask

  // One frame as seen by the core: config beat, nbeats samples in order, then an
  // output wait of wait_cyc cycles and (optionally) the output tlast handshake.
  task automatic run_frame(input bit bp, input logic fwd_exp, input logic next_fwd, input int nbeats,
                           input bit do_done, input int wait_cyc, output int cfg_wait);
    int n, k;
    foreach (frame_data[i]) frame_data[i] = $urandom;
    cfg_wait = 0;
    src_tvalid = 1'b1;
    fft_din_tready = 1'b1;
    for (n = 0; n < 20; n++) begin
      fft_cfg_tready = (bp && n < 5) ? 1'($urandom % 2) : 1'b1;
      @(negedge clk);
      chk("cfg_frame_cnt", frame_cnt, exp_frames);
      chk("cfg_din_blocked", {fft_din_tvalid, src_tready}, 0);
      if (fft_cfg_tvalid) chk("cfg_tdata", fft_cfg_tdata, {7'b0, fwd_exp});
      else cfg_wait++;
      if (fft_cfg_tvalid && fft_cfg_tready) break;
      step;
    end
    chk("cfg_handshake", n < 20, 1);
    step;
    fft_cfg_tready = 1'b0;
    k = 0;
    for (n = 0; n < 400 && k < nbeats; n++) begin
      src_tvalid = bp ? ($urandom % 3 != 0) : 1'b1;
      fft_din_tready = bp ? n[0] : 1'b1;
      start = bp ? 1'($urandom % 2) : 1'b0;
      src_tdata = src_tvalid ? frame_data[k] : $urandom;
      @(negedge clk);
      chk("din_tvalid", fft_din_tvalid, src_tvalid);
      chk("src_tready", src_tready, fft_din_tready);
      chk("din_tlast", fft_din_tlast, k == NFFT - 1);
      chk("busy_stream", busy, 1);
      if (src_tvalid && fft_din_tready) begin
        chk("din_tdata", fft_din_tdata, frame_data[k]);
        k++;
      end
      step;
    end
    start = 1'b0;
    chk("beat_count", k, nbeats);
    if (!bp) chk("no_bubble", n, nbeats);
    if (nbeats < NFFT) return;
    src_tvalid = 1'b1;
    fft_din_tready = 1'b1;
    for (int d = 0; d < wait_cyc; d++) begin
      {fft_dout_tvalid, fft_dout_tready, fft_dout_tlast} = 3'($urandom_range(0, 6));
      @(negedge clk);
      chk("wait_busy", busy, 1);
      chk("wait_blocked", {fft_din_tvalid, src_tready, fft_cfg_tvalid, fft_din_tlast}, 0);
      chk("wait_err", err, exp_err);
      step;
    end
    {fft_dout_tvalid, fft_dout_tready, fft_dout_tlast} = 3'b000;
    if (!do_done) return;
    fwd_inv = next_fwd;
    {fft_dout_tvalid, fft_dout_tready, fft_dout_tlast} = 3'b111;
    step;
    {fft_dout_tvalid, fft_dout_tready, fft_dout_tlast} = 3'b000;
    exp_frames++;
  endtask

  task automatic chk_idle(input string name);
    @(negedge clk);
    chk({name, "_frame_cnt"}, frame_cnt, exp_frames);
    chk({name, "_busy"}, busy, 0);
    step;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 3'b100};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 3'b010};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 3'b011};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 3'b000};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 3'b011};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 3'b001};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 3'b001};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 3'b000};
    rst = 1'b1; start = 1'b0; cont_mode = 1'b0; fwd_inv = 1'b0;
    src_tdata = '0; src_tvalid = 1'b1; fft_cfg_tready = 1'b1; fft_din_tready = 1'b1;
    {fft_dout_tvalid, fft_dout_tready, fft_dout_tlast} = 3'b000;
    ev_tlast_unexpected = 1'b0; ev_tlast_missing = 1'b0; err_clr = 1'b0;
    exp_frames = '0; exp_err = '0;
    repeat (3) step;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {fft_cfg_tvalid, fft_din_tvalid, fft_din_tlast, src_tready}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err", err, 0);
    step;
    // single forward frame, always-ready core
    pulse_start(1'b1);
    run_frame(1'b0, 1'b1, 1'b0, NFFT, 1'b1, 3, w);
    chk("t1_cfg_wait", w, 0);
    chk_idle("t1");
    // backpressure on both sides
    pulse_start(1'b0);
    run_frame(1'b1, 1'b0, 1'b0, NFFT, 1'b1, 5, w);
    chk_idle("t2");
    // continuous run with alternating direction; cont_mode dropped during the last frame
    cont_mode = 1'b1;
    pulse_start(1'b1);
    run_frame(1'b0, 1'b1, 1'b0, NFFT, 1'b1, 40, w);
    run_frame(1'b0, 1'b0, 1'b1, NFFT, 1'b1, 40, w);
    chk("t3_cfg_gap2", w, 0);
    cont_mode = 1'b0;
    run_frame(1'b0, 1'b1, 1'b0, NFFT, 1'b1, 40, w);
    chk("t3_cfg_gap3", w, 0);
    chk_idle("t3");
    // output never completes: watchdog fires even with cont_mode set
    cont_mode = 1'b1;
    pulse_start(1'b0);
    run_frame(1'b0, 1'b0, 1'b0, NFFT, 1'b0, TIMEOUT, w);
    exp_err = 3'b100;
    @(negedge clk);
    chk("t4_err_tmo", err, exp_err);
    chk("t4_idle", busy, 0);
    cont_mode = 1'b0;
    step;
    // sticky error set/clear sequence
    for (int i = 0; i < 8; i++) begin
      {ev_tlast_unexpected, ev_tlast_missing, err_clr} = {tbl[i].unexp, tbl[i].miss, tbl[i].clr};
      step;
      {ev_tlast_unexpected, ev_tlast_missing, err_clr} = 3'b000;
      @(negedge clk);
      chk($sformatf("err_tbl%0d", i), err, tbl[i].exp);
      exp_err = tbl[i].exp;
      step;
    end
    // reset after seven samples, then a clean frame
    pulse_start(1'b1);
    run_frame(1'b0, 1'b1, 1'b0, 7, 1'b0, 0, w);
    ev_tlast_unexpected = 1'b1;
    step;
    ev_tlast_unexpected = 1'b0;
    src_tvalid = 1'b1; fft_din_tready = 1'b1; rst = 1'b1;
    step;
    exp_frames = '0; exp_err = '0;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_outs", {fft_cfg_tvalid, fft_din_tvalid, fft_din_tlast, src_tready}, 0);
    chk("t5_frame_cnt", frame_cnt, 0);
    chk("t5_err", err, 0);
    rst = 1'b0;
    step;
    pulse_start(1'b0);
    run_frame(1'b0, 1'b0, 1'b0, NFFT, 1'b1, 2, w);
    chk_idle("t5");
    // frame counter wrap
    force dut.frame_cnt = 16'hFFFF;
    step;
    release dut.frame_cnt;
    exp_frames = 16'hFFFF;
    pulse_start(1'b1);
    run_frame(1'b0, 1'b1, 1'b0, NFFT, 1'b1, 2, w);
    chk_idle("t6_wrap");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
